microword_issuer: RTL and testbench
===================================

Name: microword_issuer

Overview:
- Drives the microaddress counter's command interface.
- Takes the microword returned by the synchronous microcode ROM for the counter's current address and decodes its sequencing field into the counter's cmd/load_addr inputs.
- Presents the control field to the datapath, with a commit strobe.
- Mirrors the counter's 4-entry call stack depth, applies stalls, and traps halt, stack overflow, stack underflow and reserved sequencing codes.

Parameters:
- CTRL_W, 16, width of the datapath control field in the microword.
- STACK_DEPTH, 4, call stack entries; must equal the microaddress counter's stack size.
- UADDR_W, $bits(microaddr_types::uaddr), microaddress width; derived, never overridden.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; same net as the microaddress counter's reset.
- uword  in  CTRL_W+UADDR_W+3  ROM read data for the address the counter held on the previous cycle.
- stall  in  1  datapath hold request; the current microword must not commit.
- resume  in  1  leave HALTED.
- cmd  out  microaddr_types::cmd  to the microaddress counter.
- load_addr  out  microaddr_types::uaddr  to the microaddress counter.
- ctrl  out  CTRL_W  datapath control field.
- ctrl_valid  out  1  ctrl commits this cycle.
- depth  out  $clog2(STACK_DEPTH+1)  current call depth, 0..STACK_DEPTH.
- halted  out  1  in HALTED.
- fault  out  1  in FAULT.

Behaviour:
- Microword fields:
  - [2:0] seq: 0 INC, 1 LOAD, 2 LOADNE, 3 CALL, 4 RET, 5 HALT, 6 and 7 reserved.
  - [UADDR_W+2:3] target.
  - [top CTRL_W bits] ctrl.
- State register values: FETCH, EXEC, HALTED, FAULT. reset forces state FETCH, depth 0.
- Reset outputs: cmd NONE, load_addr 0, ctrl 0, ctrl_valid 0, halted 0, fault 0.
- All outputs are combinational from the registered state and uword; there are no registered outputs.
- FETCH: the ROM is reading the counter address.
  - cmd NONE, ctrl 0, ctrl_valid 0.
  - Next state is EXEC unconditionally.
- EXEC with stall=1:
  - ctrl = uword ctrl, ctrl_valid 0, cmd NONE.
  - Stay in EXEC. uword stays stable because the address is unchanged.
- EXEC with stall=0: ctrl = uword ctrl, ctrl_valid 1, load_addr = target. Then, by seq:
  - INC: cmd INC, go to FETCH.
  - LOAD: cmd LOAD, go to FETCH.
  - LOADNE: cmd LOADNE, go to FETCH; zflag is evaluated by the counter, not here.
  - CALL, depth<STACK_DEPTH: cmd CALL, depth+1, go to FETCH.
  - CALL, depth==STACK_DEPTH: cmd NONE, ctrl_valid 0, go to FAULT.
  - RET, depth>0: cmd RET, depth-1, go to FETCH.
  - RET, depth==0: cmd NONE, ctrl_valid 0, go to FAULT.
  - HALT: cmd NONE, ctrl_valid 1, go to HALTED.
  - Reserved codes (6, 7): cmd NONE, ctrl_valid 0, go to FAULT.
- HALTED:
  - halted 1, cmd NONE, ctrl 0.
  - resume=1: issue cmd INC this cycle, go to FETCH.
  - resume is ignored in every other state.
- FAULT:
  - fault 1, cmd NONE, ctrl 0, ctrl_valid 0.
  - Sticky until reset; depth frozen at its value when the fault occurred.
- Throughput: one microword per 2 cycles when unstalled. The first ctrl_valid after reset release occurs 2 cycles later, for address 0.
- cmd is never driven to a value outside the six enumerated commands.
- Reset in any state, including mid-stall or HALTED, wins over all other inputs on that edge.
- Simultaneous stall=1 and a faulting seq: no fault until stall drops.

Test Plan:
- Reset, then ROM[0]=INC/ctrl 0x1234, ROM[1]=HALT -> cmd sequence NONE,INC,NONE,NONE(halt); ctrl_valid pulses at cycles 2 and 4 with ctrl 0x1234 then ROM[1].ctrl; halted=1.
- ROM[0]=CALL target 0x10, ROM[0x10]=RET, ROM[1]=HALT -> depth 0→1→0; the counter addresses go 0,0x10,1; halted=1 with fault=0.
- Five nested CALLs (each to the next address) -> depth reaches 4; the fifth CALL gives cmd NONE, fault=1, depth stays 4; cmd stays NONE for 20 cycles.
- RET as the first microword -> fault=1, depth 0, ctrl_valid never asserted. Separately, seq=6 -> fault=1.
- Hold stall=1 for 3 EXEC cycles on a LOAD 0x22 -> cmd NONE, ctrl_valid 0 for 3 cycles; then one LOAD with ctrl_valid=1; next ctrl_valid for address 0x22.
- Pulse reset while in HALTED with depth 2, and again mid-stall -> the next cycle shows FETCH, depth 0, halted 0, fault 0; the first commit is for address 0.

Source files
------------

// File: rtl/microword_issuer.sv
// rtl/microword_issuer.sv - decodes ROM microwords into microaddress counter commands and datapath control
package microaddr_types;
    typedef logic [7:0] uaddr;
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_INC    = 3'd1,
        CMD_LOAD   = 3'd2,
        CMD_LOADNE = 3'd3,
        CMD_CALL   = 3'd4,
        CMD_RET    = 3'd5
    } cmd;
endpackage

module microword_issuer #(
    parameter int CTRL_W = 16,
    parameter int STACK_DEPTH = 4,
    localparam int UADDR_W = $bits(microaddr_types::uaddr),
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CTRL_W+UADDR_W+2:0]   uword,
    input  logic                        stall,
    input  logic                        resume,
    output microaddr_types::cmd         cmd,
    output microaddr_types::uaddr       load_addr,
    output logic [CTRL_W-1:0]           ctrl,
    output logic                        ctrl_valid,
    output logic [DEPTH_W-1:0]          depth,
    output logic                        halted,
    output logic                        fault
);
    localparam logic [2:0] SEQ_INC    = 3'd0;
    localparam logic [2:0] SEQ_LOAD   = 3'd1;
    localparam logic [2:0] SEQ_LOADNE = 3'd2;
    localparam logic [2:0] SEQ_CALL   = 3'd3;
    localparam logic [2:0] SEQ_RET    = 3'd4;
    localparam logic [2:0] SEQ_HALT   = 3'd5;

    typedef enum logic [1:0] {FETCH, EXEC, HALTED, FAULT} state_t;

    state_t               state;
    state_t               next_state;
    logic [DEPTH_W-1:0]   next_depth;

    logic [2:0]           seq;
    logic [UADDR_W-1:0]   target;
    logic [CTRL_W-1:0]    uword_ctrl;

    assign seq        = uword[2:0];
    assign target     = uword[UADDR_W+2:3];
    assign uword_ctrl = uword[CTRL_W+UADDR_W+2 -: CTRL_W];

    always_comb begin
        cmd        = microaddr_types::CMD_NONE;
        load_addr  = '0;
        ctrl       = '0;
        ctrl_valid = 1'b0;
        halted     = (state == HALTED);
        fault      = (state == FAULT);
        next_state = state;
        next_depth = depth;
        case (state)
            FETCH: next_state = EXEC;
            EXEC: begin
                ctrl = uword_ctrl;
                // A stalled microword is shown but neither committed nor sequenced.
                if (!stall) begin
                    ctrl_valid = 1'b1;
                    load_addr  = target;
                    next_state = FETCH;
                    case (seq)
                        SEQ_INC:    cmd = microaddr_types::CMD_INC;
                        SEQ_LOAD:   cmd = microaddr_types::CMD_LOAD;
                        SEQ_LOADNE: cmd = microaddr_types::CMD_LOADNE;
                        SEQ_CALL: begin
                            if (depth < DEPTH_W'(STACK_DEPTH)) begin
                                cmd        = microaddr_types::CMD_CALL;
                                next_depth = depth + 1'b1;
                            end else begin
                                ctrl_valid = 1'b0;
                                next_state = FAULT;
                            end
                        end
                        SEQ_RET: begin
                            if (depth != '0) begin
                                cmd        = microaddr_types::CMD_RET;
                                next_depth = depth - 1'b1;
                            end else begin
                                ctrl_valid = 1'b0;
                                next_state = FAULT;
                            end
                        end
                        SEQ_HALT: next_state = HALTED;
                        default: begin
                            ctrl_valid = 1'b0;
                            next_state = FAULT;
                        end
                    endcase
                end
            end
            HALTED: begin
                if (resume) begin
                    cmd        = microaddr_types::CMD_INC;
                    next_state = FETCH;
                end
            end
            default: next_state = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            depth <= '0;
        end else begin
            state <= next_state;
            depth <= next_depth;
        end
    end
endmodule

// File: tb/tb_microword_issuer.sv
// tb/tb_microword_issuer.sv - directed bench with counter and ROM models around microword_issuer
module tb_microword_issuer;
    logic                  clk = 1'b0;
    logic                  reset;
    logic [26:0]           uword;
    logic                  stall;
    logic                  resume;
    microaddr_types::cmd   cmd;
    microaddr_types::uaddr load_addr;
    logic [15:0]           ctrl;
    logic                  ctrl_valid;
    logic [2:0]            depth;
    logic                  halted;
    logic                  fault;

    int checks = 0;
    int errors = 0;

    logic [26:0] rom [256];
    logic [7:0]  addr;
    logic [7:0]  rd_addr;
    logic [7:0]  stk [4];
    logic [2:0]  sp;

    microword_issuer dut (
        .clk(clk), .reset(reset), .uword(uword), .stall(stall), .resume(resume),
        .cmd(cmd), .load_addr(load_addr), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
        .depth(depth), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Microaddress counter and synchronous ROM, zflag tied low.
    always @(posedge clk) begin
        uword   <= rom[addr];
        rd_addr <= addr;
        if (reset) begin
            addr <= 8'h00;
            sp   <= 3'd0;
        end else begin
            case (cmd)
                microaddr_types::CMD_INC:    addr <= addr + 8'd1;
                microaddr_types::CMD_LOAD:   addr <= load_addr;
                microaddr_types::CMD_LOADNE: addr <= load_addr;
                microaddr_types::CMD_CALL: begin
                    stk[sp[1:0]] <= addr + 8'd1;
                    sp           <= sp + 3'd1;
                    addr         <= load_addr;
                end
                microaddr_types::CMD_RET: begin
                    addr <= stk[sp[1:0] - 2'd1];
                    sp   <= sp - 3'd1;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [26:0] mkw(input logic [2:0] s, input logic [7:0] t, input logic [15:0] c);
        return {c, t, s};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 27'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 1 (FETCH) after reset release.
    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; resume = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cmd !== microaddr_types::CMD_NONE) begin errors++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
        checks++; if (load_addr !== 8'h00) begin errors++; $display("FAIL reset_load_addr: got %0h expected 0", load_addr); end
        checks++; if (ctrl !== 16'h0 || ctrl_valid !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got %0h/%0b expected 0/0", ctrl, ctrl_valid); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0 || depth !== 3'd0) begin errors++; $display("FAIL reset_status: got h%0b f%0b d%0d expected 0 0 0", halted, fault, depth); end
    endtask

    task automatic test_inc_halt();
        clear_rom();
        rom[0] = mkw(3'd0, 8'h00, 16'h1234);
        rom[1] = mkw(3'd5, 8'h00, 16'hbeef);
        do_reset();
        checks++; if (cmd !== microaddr_types::CMD_NONE || ctrl_valid !== 1'b0) begin errors++; $display("FAIL inc_c1: got cmd %0d v %0b expected 0 0", cmd, ctrl_valid); end
        tick();
        checks++; if (cmd !== microaddr_types::CMD_INC || ctrl_valid !== 1'b1 || ctrl !== 16'h1234) begin errors++; $display("FAIL inc_c2: got cmd %0d v %0b ctrl %0h expected 1 1 1234", cmd, ctrl_valid, ctrl); end
        tick();
        checks++; if (cmd !== microaddr_types::CMD_NONE || ctrl_valid !== 1'b0) begin errors++; $display("FAIL inc_c3: got cmd %0d v %0b expected 0 0", cmd, ctrl_valid); end
        tick();
        checks++; if (cmd !== microaddr_types::CMD_NONE || ctrl_valid !== 1'b1 || ctrl !== 16'hbeef) begin errors++; $display("FAIL halt_c4: got cmd %0d v %0b ctrl %0h expected 0 1 beef", cmd, ctrl_valid, ctrl); end
        tick();
        checks++; if (halted !== 1'b1 || ctrl !== 16'h0 || cmd !== microaddr_types::CMD_NONE) begin errors++; $display("FAIL halted_c5: got h %0b ctrl %0h cmd %0d expected 1 0 0", halted, ctrl, cmd); end
        resume = 1'b1; #1;
        checks++; if (cmd !== microaddr_types::CMD_INC) begin errors++; $display("FAIL resume_cmd: got %0d expected 1", cmd); end
        tick(); resume = 1'b0; #1;
        checks++; if (halted !== 1'b0 || addr !== 8'h02) begin errors++; $display("FAIL resume_fetch: got h %0b addr %0h expected 0 2", halted, addr); end
    endtask

    task automatic test_call_ret();
        clear_rom();
        rom[0]     = mkw(3'd3, 8'h10, 16'h0001);
        rom[8'h10] = mkw(3'd4, 8'h00, 16'h0002);
        rom[1]     = mkw(3'd5, 8'h00, 16'h0003);
        do_reset();
        tick();
        checks++; if (cmd !== microaddr_types::CMD_CALL || load_addr !== 8'h10 || depth !== 3'd0) begin errors++; $display("FAIL call_issue: got cmd %0d la %0h d %0d expected 4 10 0", cmd, load_addr, depth); end
        tick();
        checks++; if (depth !== 3'd1 || addr !== 8'h10) begin errors++; $display("FAIL call_depth: got d %0d addr %0h expected 1 10", depth, addr); end
        tick();
        checks++; if (cmd !== microaddr_types::CMD_RET || ctrl !== 16'h0002 || rd_addr !== 8'h10) begin errors++; $display("FAIL ret_issue: got cmd %0d ctrl %0h ra %0h expected 5 2 10", cmd, ctrl, rd_addr); end
        tick();
        checks++; if (depth !== 3'd0 || addr !== 8'h01) begin errors++; $display("FAIL ret_depth: got d %0d addr %0h expected 0 1", depth, addr); end
        tick(); tick();
        checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL call_halt: got h %0b f %0b expected 1 0", halted, fault); end
    endtask

    task automatic test_overflow();
        int bad;
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = mkw(3'd3, 8'(i + 1), 16'h00a0);
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        checks++; if (cmd !== microaddr_types::CMD_CALL || depth !== 3'd3) begin errors++; $display("FAIL call4: got cmd %0d d %0d expected 4 3", cmd, depth); end
        tick(); tick();
        checks++; if (cmd !== microaddr_types::CMD_NONE || ctrl_valid !== 1'b0 || depth !== 3'd4) begin errors++; $display("FAIL call5: got cmd %0d v %0b d %0d expected 0 0 4", cmd, ctrl_valid, depth); end
        tick();
        checks++; if (fault !== 1'b1 || depth !== 3'd4 || ctrl !== 16'h0) begin errors++; $display("FAIL overflow_fault: got f %0b d %0d ctrl %0h expected 1 4 0", fault, depth, ctrl); end
        bad = 0;
        resume = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd !== microaddr_types::CMD_NONE || fault !== 1'b1 || depth !== 3'd4 || ctrl_valid !== 1'b0) bad++;
        end
        resume = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL fault_sticky: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_underflow_reserved();
        int vseen;
        clear_rom();
        rom[0] = mkw(3'd4, 8'h00, 16'h7777);
        do_reset();
        vseen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ctrl_valid === 1'b1) vseen++;
            tick();
        end
        checks++; if (fault !== 1'b1 || depth !== 3'd0 || vseen !== 0) begin errors++; $display("FAIL underflow: got f %0b d %0d v %0d expected 1 0 0", fault, depth, vseen); end
        rom[0] = mkw(3'd6, 8'h00, 16'h7777);
        do_reset();
        tick();
        checks++; if (ctrl_valid !== 1'b0 || cmd !== microaddr_types::CMD_NONE) begin errors++; $display("FAIL reserved_exec: got v %0b cmd %0d expected 0 0", ctrl_valid, cmd); end
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL reserved_fault: got %0b expected 1", fault); end
    endtask

    task automatic test_stall();
        int bad;
        clear_rom();
        rom[0]     = mkw(3'd1, 8'h22, 16'h5555);
        rom[8'h22] = mkw(3'd5, 8'h00, 16'h0a0a);
        do_reset();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); stall = 1'b1; #1;
            if (cmd !== microaddr_types::CMD_NONE || ctrl_valid !== 1'b0 || ctrl !== 16'h5555) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
        tick(); stall = 1'b0; #1;
        checks++; if (cmd !== microaddr_types::CMD_LOAD || ctrl_valid !== 1'b1 || load_addr !== 8'h22) begin errors++; $display("FAIL stall_release: got cmd %0d v %0b la %0h expected 2 1 22", cmd, ctrl_valid, load_addr); end
        tick(); tick();
        checks++; if (ctrl_valid !== 1'b1 || ctrl !== 16'h0a0a || rd_addr !== 8'h22) begin errors++; $display("FAIL load_target: got v %0b ctrl %0h ra %0h expected 1 a0a 22", ctrl_valid, ctrl, rd_addr); end
        // A reserved seq under stall must not fault until stall drops.
        rom[0] = mkw(3'd7, 8'h00, 16'h0);
        do_reset();
        stall = 1'b1;
        tick(); tick(); tick();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL stall_nofault: got %0b expected 0", fault); end
        stall = 1'b0;
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL stall_fault: got %0b expected 1", fault); end
    endtask

    task automatic test_reset_mid();
        clear_rom();
        rom[0]     = mkw(3'd3, 8'h10, 16'h0c01);
        rom[8'h10] = mkw(3'd3, 8'h20, 16'h0c02);
        rom[8'h20] = mkw(3'd5, 8'h00, 16'h0c03);
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        checks++; if (halted !== 1'b1 || depth !== 3'd2) begin errors++; $display("FAIL pre_reset_halt: got h %0b d %0d expected 1 2", halted, depth); end
        reset = 1'b1; resume = 1'b1;
        tick(); reset = 1'b0; resume = 1'b0; #1;
        checks++; if (depth !== 3'd0 || halted !== 1'b0 || fault !== 1'b0 || cmd !== microaddr_types::CMD_NONE || ctrl_valid !== 1'b0) begin errors++; $display("FAIL reset_from_halt: got d %0d h %0b f %0b cmd %0d v %0b expected 0 0 0 0 0", depth, halted, fault, cmd, ctrl_valid); end
        tick(); stall = 1'b1; #1;
        checks++; if (ctrl_valid !== 1'b0 || ctrl !== 16'h0c01) begin errors++; $display("FAIL mid_stall: got v %0b ctrl %0h expected 0 c01", ctrl_valid, ctrl); end
        reset = 1'b1;
        tick(); reset = 1'b0; stall = 1'b0; #1;
        checks++; if (depth !== 3'd0 || cmd !== microaddr_types::CMD_NONE || ctrl_valid !== 1'b0 || ctrl !== 16'h0) begin errors++; $display("FAIL reset_from_stall: got d %0d cmd %0d v %0b ctrl %0h expected 0 0 0 0", depth, cmd, ctrl_valid, ctrl); end
        tick();
        checks++; if (ctrl_valid !== 1'b1 || cmd !== microaddr_types::CMD_CALL || rd_addr !== 8'h00 || ctrl !== 16'h0c01) begin errors++; $display("FAIL first_commit: got v %0b cmd %0d ra %0h ctrl %0h expected 1 4 0 c01", ctrl_valid, cmd, rd_addr, ctrl); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; resume = 1'b0;
        clear_rom();
        test_reset();
        test_inc_halt();
        test_call_ret();
        test_overflow();
        test_underflow_reserved();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
